// File: rtl/draw_point_fb_writer.sv
// -----------------------------------------------------------------------------
// draw_point_fb_writer
//
// Turns the DrawPoint point stream into 16-bit pixel writes on an Avalon-MM
// write master. Each point is bounds-checked on capture. Accepted points are
// converted to a word address and pushed into a small FIFO, so the point source
// never has to wait on frame-buffer stalls. A two-state write master drains the
// FIFO in arrival order, one transfer per cycle when the slave does not stall.
//
// Ports
//   csi_clock_clk          clock, shared with the DrawPoint master
//   rsi_reset_reset_n      asynchronous active-low reset
//   coe_dps_ul1Update      point strobe, one point per high cycle
//   coe_dps_ul9PosX/PosY   point coordinates
//   coe_dps_ul12Rgb12Data  point colour
//   avm_fb_*               Avalon-MM write master into the frame buffer
//   coe_stat_ul16Dropped*  saturating drop counters (out of range / FIFO full)
//   coe_stat_ul1Busy       capture stage, FIFO or write master still active
// -----------------------------------------------------------------------------
module draw_point_fb_writer #(
   parameter int unsigned FB_WIDTH   = 320,
   parameter int unsigned FB_HEIGHT  = 240,
   parameter int unsigned FB_BASE    = 0,
   parameter int unsigned ADDR_W     = 24,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              csi_clock_clk,
   input  logic              rsi_reset_reset_n,
   input  logic              coe_dps_ul1Update,
   input  logic [8:0]        coe_dps_ul9PosX,
   input  logic [8:0]        coe_dps_ul9PosY,
   input  logic [11:0]       coe_dps_ul12Rgb12Data,
   output logic [ADDR_W-1:0] avm_fb_address,
   output logic              avm_fb_write,
   output logic [15:0]       avm_fb_writedata,
   output logic [1:0]        avm_fb_byteenable,
   input  logic              avm_fb_waitrequest,
   output logic [15:0]       coe_stat_ul16DroppedRange,
   output logic [15:0]       coe_stat_ul16DroppedFull,
   output logic              coe_stat_ul1Busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } fb_req_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   // ---------------------------------------------------------------- stage 1
   logic        s1_valid_d, s1_valid_q;
   logic [8:0]  s1_x_d, s1_x_q;
   logic [8:0]  s1_y_d, s1_y_q;
   logic [11:0] s1_rgb_d, s1_rgb_q;
   logic        in_range;

   always_comb begin
      in_range   = (32'(coe_dps_ul9PosX) < FB_WIDTH) &&
                   (32'(coe_dps_ul9PosY) < FB_HEIGHT);
      s1_valid_d = coe_dps_ul1Update && in_range;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      s1_rgb_d   = s1_rgb_q;
      if (coe_dps_ul1Update) begin
         s1_x_d   = coe_dps_ul9PosX;
         s1_y_d   = coe_dps_ul9PosY;
         s1_rgb_d = coe_dps_ul12Rgb12Data;
      end
   end

   // ---------------------------------------------------------------- stage 2
   // Address arithmetic is done at ADDR_W bits so it wraps modulo 2^ADDR_W.
   fb_req_t push_req;

   always_comb begin
      push_req.addr = ADDR_W'(FB_BASE)
                    + ADDR_W'(s1_y_q) * ADDR_W'(FB_WIDTH)
                    + ADDR_W'(s1_x_q);
      push_req.data = {4'h0, s1_rgb_q};
   end

   // ------------------------------------------------------------------- FIFO
   fb_req_t          fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
   logic [PTR_W:0]   count_d, count_q;
   logic             fifo_empty, fifo_full;
   logic             push, pop, drop_full;
   fb_req_t          head;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign head       = fifo_mem_q[rd_ptr_q];

   // A full FIFO still accepts the push when the write master pops the same
   // cycle, so a stall-free stream never loses points.
   always_comb begin
      push      = s1_valid_q && (!fifo_full || pop);
      drop_full = s1_valid_q && fifo_full && !pop;
      wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d   = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge csi_clock_clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= push_req;
   end

   // ------------------------------------------------------- write master FSM
   state_t            state_d, state_q;
   logic              write_d, write_q;
   logic [ADDR_W-1:0] address_d, address_q;
   logic [15:0]       writedata_d, writedata_q;
   logic [1:0]        byteenable_d, byteenable_q;

   always_comb begin
      state_d      = state_q;
      pop          = 1'b0;
      write_d      = write_q;
      address_d    = address_q;
      writedata_d  = writedata_q;
      byteenable_d = 2'b11;
      case (state_q)
         ST_IDLE: begin
            write_d = 1'b0;
            if (!fifo_empty) begin
               pop         = 1'b1;
               write_d     = 1'b1;
               address_d   = head.addr;
               writedata_d = head.data;
               state_d     = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Transfer completes on an edge without waitrequest; chain the
            // next entry straight in so there is no idle cycle between writes.
            if (!avm_fb_waitrequest) begin
               if (!fifo_empty) begin
                  pop         = 1'b1;
                  address_d   = head.addr;
                  writedata_d = head.data;
               end else begin
                  write_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            write_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------- drop counters
   logic [15:0] drop_range_d, drop_range_q;
   logic [15:0] drop_full_d, drop_full_q;

   always_comb begin
      drop_range_d = drop_range_q;
      drop_full_d  = drop_full_q;
      if (coe_dps_ul1Update && !in_range && (drop_range_q != 16'hFFFF))
         drop_range_d = drop_range_q + 16'd1;
      if (drop_full && (drop_full_q != 16'hFFFF))
         drop_full_d = drop_full_q + 16'd1;
   end

   // --------------------------------------------------------------- registers
   always_ff @(posedge csi_clock_clk or negedge rsi_reset_reset_n) begin
      if (!rsi_reset_reset_n) begin
         s1_valid_q   <= 1'b0;
         s1_x_q       <= '0;
         s1_y_q       <= '0;
         s1_rgb_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= ST_IDLE;
         write_q      <= 1'b0;
         address_q    <= '0;
         writedata_q  <= '0;
         byteenable_q <= 2'b00;
         drop_range_q <= '0;
         drop_full_q  <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_x_q       <= s1_x_d;
         s1_y_q       <= s1_y_d;
         s1_rgb_q     <= s1_rgb_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         write_q      <= write_d;
         address_q    <= address_d;
         writedata_q  <= writedata_d;
         byteenable_q <= byteenable_d;
         drop_range_q <= drop_range_d;
         drop_full_q  <= drop_full_d;
      end
   end

   assign avm_fb_address            = address_q;
   assign avm_fb_write              = write_q;
   assign avm_fb_writedata          = writedata_q;
   assign avm_fb_byteenable         = byteenable_q;
   assign coe_stat_ul16DroppedRange = drop_range_q;
   assign coe_stat_ul16DroppedFull  = drop_full_q;
   assign coe_stat_ul1Busy          = s1_valid_q || !fifo_empty || (state_q == ST_WRITE);

endmodule

// File: tb/tb_draw_point_fb_writer.sv
// -----------------------------------------------------------------------------
// Testbench for draw_point_fb_writer. A negedge monitor scores every completed
// transfer against a queue of expected pixel writes built from the point rules
// (in-range test, address = y*width + x, data = colour). Scenario tasks drive
// points and check counters, latency, stalls and reset behaviour inline.
// -----------------------------------------------------------------------------
module tb_draw_point_fb_writer;
   localparam int unsigned FB_WIDTH   = 320;
   localparam int unsigned FB_HEIGHT  = 240;
   localparam int unsigned ADDR_W     = 24;
   localparam int unsigned FIFO_DEPTH = 8;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b0;
   logic              upd     = 1'b0;
   logic [8:0]        px      = '0;
   logic [8:0]        py      = '0;
   logic [11:0]       rgb     = '0;
   logic              waitreq = 1'b0;
   logic [ADDR_W-1:0] fb_addr;
   logic              fb_wr;
   logic [15:0]       fb_data;
   logic [1:0]        fb_be;
   logic [15:0]       drop_rng;
   logic [15:0]       drop_full;
   logic              busy;

   int checks   = 0;
   int errors   = 0;
   int n_writes = 0;
   int unsigned exp_rng  = 0;
   int unsigned exp_full = 0;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } wr_t;
   wr_t exp_q[$];
   wr_t mon_w;

   logic              hold_chk  = 1'b0;
   logic [ADDR_W-1:0] hold_addr = '0;
   logic [15:0]       hold_data = '0;

   draw_point_fb_writer #(
      .FB_WIDTH   (FB_WIDTH),
      .FB_HEIGHT  (FB_HEIGHT),
      .FB_BASE    (0),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .csi_clock_clk             (clk),
      .rsi_reset_reset_n         (rst_n),
      .coe_dps_ul1Update         (upd),
      .coe_dps_ul9PosX           (px),
      .coe_dps_ul9PosY           (py),
      .coe_dps_ul12Rgb12Data     (rgb),
      .avm_fb_address            (fb_addr),
      .avm_fb_write              (fb_wr),
      .avm_fb_writedata          (fb_data),
      .avm_fb_byteenable         (fb_be),
      .avm_fb_waitrequest        (waitreq),
      .coe_stat_ul16DroppedRange (drop_rng),
      .coe_stat_ul16DroppedFull  (drop_full),
      .coe_stat_ul1Busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Transfer monitor and scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_chk) begin
            checks++;
            if (fb_wr !== 1'b1 || fb_addr !== hold_addr || fb_data !== hold_data) begin
               errors++;
               $display("FAIL stall_hold write=%b addr=%0d data=%h required write=1 addr=%0d data=%h",
                        fb_wr, fb_addr, fb_data, hold_addr, hold_data);
            end
         end
         if (fb_wr === 1'b1) begin
            checks++;
            if (fb_be !== 2'b11) begin
               errors++;
               $display("FAIL byteenable got %b required 11", fb_be);
            end
            if (waitreq === 1'b0) begin
               n_writes++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write addr=%0d data=%h required none", fb_addr, fb_data);
               end else begin
                  mon_w = exp_q.pop_front();
                  if (fb_addr !== ADDR_W'(mon_w.addr) || fb_data !== 16'(mon_w.data)) begin
                     errors++;
                     $display("FAIL write_order addr=%0d data=%h required addr=%0d data=%h",
                              fb_addr, fb_data, mon_w.addr, mon_w.data);
                  end
               end
            end
         end
         hold_chk  = (fb_wr === 1'b1) && (waitreq === 1'b1);
         hold_addr = fb_addr;
         hold_data = fb_data;
      end else begin
         hold_chk = 1'b0;
      end
   end

   // ------------------------------------------------------------- utilities
   task automatic drive(input int unsigned x, input int unsigned y, input int unsigned c);
      upd = 1'b1;
      px  = 9'(x);
      py  = 9'(y);
      rgb = 12'(c);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      upd = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Reference model: what a point should produce, independent of timing.
   task automatic model_point(input int unsigned x, input int unsigned y, input int unsigned c);
      wr_t w;
      if (x < FB_WIDTH && y < FB_HEIGHT) begin
         w.addr = y * FB_WIDTH + x;
         w.data = c & 32'hFFF;
         exp_q.push_back(w);
      end else if (exp_rng < 65535) begin
         exp_rng++;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n   = 0;
      upd = 1'b0;
      while ((busy !== 1'b0 || fb_wr !== 1'b0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0 || fb_wr !== 1'b0) begin
         errors++;
         $display("FAIL %s drain_timeout busy=%b write=%b required 0 0", name, busy, fb_wr);
      end
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({fb_addr, fb_wr, fb_data, fb_be, drop_rng, drop_full, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got addr=%0d wr=%b data=%h be=%b rng=%0d full=%0d busy=%b required all 0",
                  fb_addr, fb_wr, fb_data, fb_be, drop_rng, drop_full, busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
      checks++;
      if (fb_be !== 2'b11 || fb_wr !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset be=%b wr=%b busy=%b required 11 0 0", fb_be, fb_wr, busy);
      end
   endtask

   task automatic test_single();
      int n0;
      n0 = n_writes;
      model_point(10, 2, 'hABC);
      drive(10, 2, 'hABC);
      idle(1);
      checks++;
      if (fb_wr !== 1'b0) begin
         errors++;
         $display("FAIL single_early write=%b at N+1 required 0", fb_wr);
      end
      idle(1);
      checks++;
      if (fb_wr !== 1'b1 || fb_addr !== 24'd650 || fb_data !== 16'h0ABC || fb_be !== 2'b11) begin
         errors++;
         $display("FAIL single_write wr=%b addr=%0d data=%h be=%b required 1 650 0abc 11",
                  fb_wr, fb_addr, fb_data, fb_be);
      end
      idle(1);
      checks++;
      if (fb_wr !== 1'b0 || busy !== 1'b0 || (n_writes - n0) != 1) begin
         errors++;
         $display("FAIL single_end wr=%b busy=%b writes=%0d required 0 0 1", fb_wr, busy, n_writes - n0);
      end
   endtask

   task automatic test_range();
      int n0;
      n0 = n_writes;
      model_point(320, 0, 1);   drive(320, 0, 1);
      model_point(0, 240, 2);   drive(0, 240, 2);
      model_point(319, 239, 3); drive(319, 239, 3);
      wait_idle("range");
      checks++;
      if (drop_rng !== 16'(exp_rng) || drop_full !== 16'd0) begin
         errors++;
         $display("FAIL range_counters rng=%0d full=%0d required %0d 0", drop_rng, drop_full, exp_rng);
      end
      checks++;
      if ((n_writes - n0) != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL range_writes writes=%0d pending=%0d required 1 0", n_writes - n0, exp_q.size());
      end
   endtask

   task automatic test_full();
      int n0;
      int bad;
      int unsigned x, y, c;
      wr_t w;
      n0      = n_writes;
      waitreq = 1'b1;
      for (int i = 0; i < 12; i++) begin
         x = $urandom_range(FB_WIDTH - 1, 0);
         y = $urandom_range(FB_HEIGHT - 1, 0);
         c = $urandom_range(4095, 0);
         if (i < 9) begin
            w.addr = y * FB_WIDTH + x;
            w.data = c;
            exp_q.push_back(w);
         end else begin
            exp_full++;
         end
         drive(x, y, c);
      end
      idle(4);
      checks++;
      if (fb_wr !== 1'b1 || fb_addr !== ADDR_W'(exp_q[0].addr) || busy !== 1'b1) begin
         errors++;
         $display("FAIL full_stalled wr=%b addr=%0d busy=%b required 1 %0d 1", fb_wr, fb_addr, busy, exp_q[0].addr);
      end
      checks++;
      if (drop_full !== 16'(exp_full)) begin
         errors++;
         $display("FAIL full_dropped got %0d required %0d", drop_full, exp_full);
      end
      waitreq = 1'b0;
      bad     = 0;
      for (int i = 0; i < 9; i++) begin
         if (fb_wr !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full_back_to_back idle_cycles=%0d required 0", bad);
      end
      checks++;
      if (fb_wr !== 1'b0 || busy !== 1'b0 || (n_writes - n0) != 9 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_drain wr=%b busy=%b writes=%0d pending=%0d required 0 0 9 0",
                  fb_wr, busy, n_writes - n0, exp_q.size());
      end
   endtask

   task automatic test_toggle();
      int n0;
      int unsigned x, y, c;
      n0 = n_writes;
      for (int i = 0; i < 12; i++) begin
         waitreq = (i % 2 == 0);
         if (i < 4) begin
            x = $urandom_range(FB_WIDTH - 1, 0);
            y = $urandom_range(FB_HEIGHT - 1, 0);
            c = $urandom_range(4095, 0);
            model_point(x, y, c);
            drive(x, y, c);
         end else begin
            idle(1);
         end
      end
      waitreq = 1'b0;
      wait_idle("toggle");
      checks++;
      if ((n_writes - n0) != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL toggle_writes writes=%0d pending=%0d required 4 0", n_writes - n0, exp_q.size());
      end
   endtask

   task automatic test_random();
      int unsigned x, y, c;
      int n;
      for (int b = 0; b < 20; b++) begin
         n = $urandom_range(9, 1);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(3, 0) == 0) begin
               x = $urandom_range(511, 0);
               y = (x >= FB_WIDTH) ? $urandom_range(511, 0) : $urandom_range(511, FB_HEIGHT);
            end else begin
               x = $urandom_range(FB_WIDTH - 1, 0);
               y = $urandom_range(FB_HEIGHT - 1, 0);
            end
            c       = $urandom_range(4095, 0);
            waitreq = 1'($urandom_range(1, 0));
            model_point(x, y, c);
            drive(x, y, c);
            if ($urandom_range(2, 0) == 0) begin
               waitreq = 1'($urandom_range(1, 0));
               idle(1);
            end
         end
         repeat ($urandom_range(5, 0)) begin
            waitreq = 1'($urandom_range(1, 0));
            idle(1);
         end
         waitreq = 1'b0;
         wait_idle("random");
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_pending got %0d required 0", exp_q.size());
      end
      checks++;
      if (drop_rng !== 16'(exp_rng) || drop_full !== 16'(exp_full)) begin
         errors++;
         $display("FAIL random_counters rng=%0d full=%0d required %0d %0d", drop_rng, drop_full, exp_rng, exp_full);
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      waitreq = 1'b1;
      for (int i = 0; i < 4; i++) drive(5 + i, 7, 16 + i);
      idle(3);
      checks++;
      if (fb_wr !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre wr=%b busy=%b required 1 1", fb_wr, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({fb_addr, fb_wr, fb_data, fb_be, drop_rng, drop_full, busy} !== '0) begin
         errors++;
         $display("FAIL rmid_async wr=%b addr=%0d be=%b rng=%0d full=%0d busy=%b required all 0",
                  fb_wr, fb_addr, fb_be, drop_rng, drop_full, busy);
      end
      exp_q.delete();
      exp_rng  = 0;
      exp_full = 0;
      n0       = n_writes;
      @(posedge clk); #1;
      waitreq = 1'b0;
      rst_n   = 1'b1;
      idle(20);
      checks++;
      if ((n_writes - n0) != 0 || fb_wr !== 1'b0 || busy !== 1'b0 ||
          drop_rng !== 16'd0 || drop_full !== 16'd0) begin
         errors++;
         $display("FAIL rmid_after writes=%0d wr=%b busy=%b rng=%0d full=%0d required 0 0 0 0 0",
                  n_writes - n0, fb_wr, busy, drop_rng, drop_full);
      end
   endtask

   task automatic test_saturate();
      int n0;
      n0  = n_writes;
      upd = 1'b1;
      px  = 9'd400;
      py  = 9'd0;
      repeat (65535) @(posedge clk);
      #1;
      idle(2);
      checks++;
      if (drop_rng !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_reach got %h required ffff", drop_rng);
      end
      upd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      idle(2);
      checks++;
      if (drop_rng !== 16'hFFFF || drop_full !== 16'd0 || (n_writes - n0) != 0) begin
         errors++;
         $display("FAIL sat_hold rng=%h full=%0d writes=%0d required ffff 0 0", drop_rng, drop_full, n_writes - n0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_range();
      test_full();
      test_toggle();
      test_random();
      test_reset_mid();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
